// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
//   scan_state_t : scanner FSM state encoding
//   cnt_width()  : bit width needed to hold a counter value 0..max_val
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        ACCEPT   = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } scan_state_t;

    // Width for a counter that must reach max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d_i   : asynchronous input bus
//   q_o   : synchronised output, two clk cycles behind d_i
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: drives one-hot column strobes, debounces the
// synchronised row returns on press and release, and reports accepted keys.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   row_keys  : raw asynchronous row returns, active-high
//   col_keys  : one-hot column drive
//   key_valid : one-cycle strobe when key_index is (re)accepted
//   key_index : row*COLS + col of the last accepted key
//   key_held  : high while the accepted key is held down
//   history   : last DIGITS accepted keys, newest in [KW-1:0]
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter  int unsigned ROWS            = 4,
    parameter  int unsigned COLS            = 4,
    parameter  int unsigned SCAN_CYCLES     = 4800,
    parameter  int unsigned DEBOUNCE_CYCLES = 960000,
    parameter  int unsigned REPEAT_CYCLES   = 0,
    parameter  int unsigned DIGITS          = 2,
    localparam int unsigned KW              = $clog2(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS-1:0]      row_keys,
    output logic [COLS-1:0]      col_keys,
    output logic                 key_valid,
    output logic [KW-1:0]        key_index,
    output logic                 key_held,
    output logic [DIGITS*KW-1:0] history
);

    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW      = $clog2(COLS);
    localparam int unsigned HW      = DIGITS * KW;
    localparam int unsigned CNT_MAX = ((SCAN_CYCLES - 1) > DEBOUNCE_CYCLES) ?
                                      (SCAN_CYCLES - 1) : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam int unsigned RPT_W   = cnt_width(REPEAT_CYCLES);

    // Synchronised row returns; the raw pins are never used directly.
    logic [ROWS-1:0] rs;

    sync_2ff #(
        .WIDTH (ROWS)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (row_keys),
        .q_o   (rs)
    );

    scan_state_t      state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [RPT_W-1:0] rpt_q,       rpt_d;
    logic [COLS-1:0]  col_keys_q,  col_keys_d;
    logic [CW-1:0]    col_idx_q,   col_idx_d;
    logic [RW-1:0]    row_cap_q,   row_cap_d;
    logic [CW-1:0]    col_cap_q,   col_cap_d;
    logic             key_valid_q, key_valid_d;
    logic [KW-1:0]    key_index_q, key_index_d;
    logic             key_held_q,  key_held_d;
    logic [HW-1:0]    history_q,   history_d;

    logic [RW-1:0]    low_row;
    logic             row_hit;
    logic [COLS-1:0]  col_keys_rot;
    logic [CW-1:0]    col_idx_nxt;
    logic [KW-1:0]    key_new;
    logic [HW-1:0]    hist_shift;
    logic             rpt_tick;

    // Lowest-index asserted row wins when several rows are returned together.
    always_comb begin
        low_row = '0;
        for (int r = int'(ROWS) - 1; r >= 0; r--) begin
            if (rs[r]) begin
                low_row = RW'(r);
            end
        end
    end

    // Captured row still asserted on the frozen column.
    assign row_hit = |(rs & (ROWS'(1) << row_cap_q));

    // Next column, wrapping COLS-1 back to column 0.
    assign col_keys_rot = {col_keys_q[COLS-2:0], col_keys_q[COLS-1]};
    assign col_idx_nxt  = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + CW'(1);

    // Key code of the captured position and the history with it pushed in.
    assign key_new    = KW'(row_cap_q) * KW'(COLS) + KW'(col_cap_q);
    assign hist_shift = (history_q << KW) | HW'(key_new);

    // Repeat period elapses when the held-cycle counter reaches its last value.
    assign rpt_tick = (REPEAT_CYCLES != 0) && (rpt_q == RPT_W'(REPEAT_CYCLES - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rpt_d       = rpt_q;
        col_keys_d  = col_keys_q;
        col_idx_d   = col_idx_q;
        row_cap_d   = row_cap_q;
        col_cap_d   = col_cap_q;
        key_valid_d = 1'b0;
        key_index_d = key_index_q;
        key_held_d  = key_held_q;
        history_d   = history_q;

        case (state_q)
            SCAN: begin
                // dwell >= 2 lets the synchroniser flush the previous column.
                if ((cnt_q >= CNT_W'(2)) && (rs != '0)) begin
                    row_cap_d = low_row;
                    col_cap_d = col_idx_q;
                    cnt_d     = '0;
                    state_d   = DEBOUNCE;
                end else if (cnt_q == CNT_W'(SCAN_CYCLES - 1)) begin
                    col_keys_d = col_keys_rot;
                    col_idx_d  = col_idx_nxt;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DEBOUNCE: begin
                if (!row_hit) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Outputs load on entry so the strobe is visible during ACCEPT.
                    cnt_d       = '0;
                    rpt_d       = '0;
                    key_valid_d = 1'b1;
                    key_index_d = key_new;
                    history_d   = hist_shift;
                    key_held_d  = 1'b1;
                    state_d     = ACCEPT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ACCEPT: begin
                state_d = HOLD;
                if (REPEAT_CYCLES != 0) begin
                    if (rpt_tick) begin
                        rpt_d       = '0;
                        key_valid_d = 1'b1;
                        history_d   = hist_shift;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end
            end

            HOLD: begin
                if (!row_hit) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else if (REPEAT_CYCLES != 0) begin
                    if (rpt_tick) begin
                        rpt_d       = '0;
                        key_valid_d = 1'b1;
                        history_d   = hist_shift;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end
            end

            RELEASE: begin
                if (row_hit) begin
                    // Release bounce: resume holding without a new strobe.
                    rpt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_held_d = 1'b0;
                    col_keys_d = col_keys_rot;
                    col_idx_d  = col_idx_nxt;
                    cnt_d      = '0;
                    state_d    = SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            rpt_q       <= '0;
            col_keys_q  <= COLS'(1);
            col_idx_q   <= '0;
            row_cap_q   <= '0;
            col_cap_q   <= '0;
            key_valid_q <= 1'b0;
            key_index_q <= '0;
            key_held_q  <= 1'b0;
            history_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            col_keys_q  <= col_keys_d;
            col_idx_q   <= col_idx_d;
            row_cap_q   <= row_cap_d;
            col_cap_q   <= col_cap_d;
            key_valid_q <= key_valid_d;
            key_index_q <= key_index_d;
            key_held_q  <= key_held_d;
            history_q   <= history_d;
        end
    end

    assign col_keys  = col_keys_q;
    assign key_valid = key_valid_q;
    assign key_index = key_index_q;
    assign key_held  = key_held_q;
    assign history   = history_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: one instance without auto-repeat and
// one with a 16-cycle repeat, each driven by a simple switch-matrix model.
module tb_keypad_scan_ctrl;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] press0, press1;
    logic [3:0]  rows0, rows1, col0, col1;
    logic        kv0, kv1, held0, held1;
    logic [3:0]  idx0, idx1;
    logic [7:0]  hist0, hist1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Switch matrix: a pressed key connects its column drive to its row.
    always_comb begin
        rows0 = '0;
        rows1 = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rows0[r] = rows0[r] | (press0[r*4+c] & col0[c]);
                rows1[r] = rows1[r] | (press1[r*4+c] & col1[c]);
            end
        end
    end

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES(0), .DIGITS(2)
    ) u_dut0 (
        .clk(clk), .reset(rst_n), .row_keys(rows0), .col_keys(col0),
        .key_valid(kv0), .key_index(idx0), .key_held(held0), .history(hist0)
    );

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES(16), .DIGITS(2)
    ) u_dut1 (
        .clk(clk), .reset(rst_n), .row_keys(rows1), .col_keys(col1),
        .key_valid(kv1), .key_index(idx1), .key_held(held1), .history(hist1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Press a key on dut0, wait for its strobe, release and wait for key_held to drop.
    task automatic press_cycle0(input int idx, input logic [7:0] hist_exp);
        int strobes = 0;
        bit seen    = 1'b0;
        bit low     = 1'b0;
        press0 = 16'(1) << idx;
        for (int k = 0; k < 80 && !seen; k++) begin
            step();
            if (kv0) begin
                seen = 1'b1;
                strobes++;
            end
        end
        check("press_seen", 32'(seen), 32'(1));
        check("press_index", 32'(idx0), 32'(idx));
        check("press_hist", 32'(hist0), 32'(hist_exp));
        press0 = '0;
        for (int k = 0; k < 80 && !low; k++) begin
            step();
            if (kv0) strobes++;
            if (!held0) low = 1'b1;
        end
        check("release_seen", 32'(low), 32'(1));
        check("press_strobes", 32'(strobes), 32'(1));
    endtask

    initial begin
        int n_kv;
        int n_low;
        int n_rpt;
        int rpt_off [4];
        bit seen;

        rst_n  = 1'b0;
        press0 = '0;
        press1 = '0;
        repeat (3) @(negedge clk);

        check("rst_col", 32'(col0), 32'h1);
        check("rst_valid", 32'(kv0), 32'h0);
        check("rst_index", 32'(idx0), 32'h0);
        check("rst_held", 32'(held0), 32'h0);
        check("rst_hist", 32'(hist0), 32'h0);
        rst_n = 1'b1;

        // Idle sweep: each column driven for 4 cycles, never a strobe.
        n_kv = 0;
        for (int j = 1; j <= 32; j++) begin
            step();
            check("sweep_col", 32'(col0), 32'(1 << ((j / 4) % 4)));
            if (kv0) n_kv++;
        end
        check("sweep_nostrobe", 32'(n_kv), 32'(0));

        // Clean press of key 10 (row 2, col 2) right as column 2 is driven.
        repeat (8) step();
        check("press_col", 32'(col0), 32'h4);
        press0 = 16'(1) << 10;
        n_kv = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (kv0) n_kv++;
            if (k == 10) check("lat_pre", 32'(kv0), 32'(0));
            if (k == 11) begin
                check("lat_hit", 32'(kv0), 32'(1));
                check("lat_index", 32'(idx0), 32'd10);
                check("lat_hist", 32'(hist0), 32'h0A);
                check("lat_held", 32'(held0), 32'(1));
            end
            if (k == 12) check("strobe_width", 32'(kv0), 32'(0));
        end
        repeat (5) begin
            step();
            if (kv0) n_kv++;
        end
        check("held_during", 32'(held0), 32'(1));
        press0 = '0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (kv0) n_kv++;
            if (k == 10) check("held_pre_drop", 32'(held0), 32'(1));
            if (k == 11) begin
                check("held_drop", 32'(held0), 32'(0));
                check("release_col", 32'(col0), 32'h8);
            end
        end
        check("clean_strobes", 32'(n_kv), 32'(1));
        check("index_stable", 32'(idx0), 32'd10);

        // Bounce: key 4 (row 1, col 0) lets go after 3 debounce cycles.
        repeat (4) step();
        check("bounce_col", 32'(col0), 32'h1);
        press0 = 16'(1) << 4;
        n_kv = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (kv0) n_kv++;
            if (k == 5) press0 = '0;
            if (k == 11) check("bounce_stay_col", 32'(col0), 32'h1);
            if (k == 12) check("bounce_next_col", 32'(col0), 32'h2);
        end
        check("bounce_nostrobe", 32'(n_kv), 32'(0));
        check("bounce_index", 32'(idx0), 32'd10);

        // History: newest key enters the low slot, oldest falls off the top.
        press_cycle0(5, 8'hA5);
        press_cycle0(15, 8'h5F);
        press_cycle0(0, 8'hF0);

        // Auto-repeat on dut1: hold key 3 (row 0, col 3).
        press1 = 16'(1) << 3;
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            step();
            if (kv1) seen = 1'b1;
        end
        check("rpt_first", 32'(seen), 32'(1));
        check("rpt_index", 32'(idx1), 32'd3);
        n_rpt = 0;
        for (int k = 0; k < 4; k++) rpt_off[k] = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (kv1) begin
                if (n_rpt < 4) rpt_off[n_rpt] = i;
                n_rpt++;
            end
        end
        check("rpt_count", 32'(n_rpt), 32'(3));
        check("rpt_off0", 32'(rpt_off[0]), 32'd16);
        check("rpt_off1", 32'(rpt_off[1]), 32'd32);
        check("rpt_off2", 32'(rpt_off[2]), 32'd48);
        check("rpt_hist", 32'(hist1), 32'h33);

        // 4-cycle release glitch: no extra strobe, key_held stays up.
        press1 = '0;
        n_kv  = 0;
        n_low = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 4) press1 = 16'(1) << 3;
            if (kv1) n_kv++;
            if (!held1) n_low++;
        end
        check("glitch_nostrobe", 32'(n_kv), 32'(0));
        check("glitch_held", 32'(n_low), 32'(0));

        // Reset while holding: immediate return to reset values.
        rst_n = 1'b0;
        #1;
        check("hold_rst_col", 32'(col1), 32'h1);
        check("hold_rst_valid", 32'(kv1), 32'h0);
        check("hold_rst_index", 32'(idx1), 32'h0);
        check("hold_rst_held", 32'(held1), 32'h0);
        check("hold_rst_hist", 32'(hist1), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Key still down: strobe only after a full scan to col 3 and a fresh debounce.
        n_kv = 0;
        for (int j = 1; j <= 23; j++) begin
            step();
            if (j < 23 && kv1) n_kv++;
            if (j == 23) begin
                check("post_rst_strobe", 32'(kv1), 32'(1));
                check("post_rst_index", 32'(idx1), 32'd3);
                check("post_rst_hist", 32'(hist1), 32'h03);
            end
        end
        check("post_rst_early", 32'(n_kv), 32'(0));
        press1 = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner that generalises the lab keypad front end. It drives one-hot column strobes, synchronises and debounces row returns, and emits a registered key index with a one-cycle valid strobe. It supports optional auto-repeat and keeps a DIGITS-deep history of accepted keys. It sits between the keypad pins and the display multiplexer, replacing the ad-hoc scan/debounce logic previously in the top level.

## Interface
- ROWS, 4, keypad rows (≥1)
- COLS, 4, keypad columns (≥2)
- SCAN_CYCLES, 4800, clk cycles each column is driven while idle (≥3)
- DEBOUNCE_CYCLES, 960000, stable cycles required on press and on release (≥1)
- REPEAT_CYCLES, 0, auto-repeat period while held; 0 disables repeat
- DIGITS, 2, depth of key history (≥1)
- KW (localparam), $clog2(ROWS*COLS), key index width
- clk  in  1  system clock (48 MHz HSOSC in the top level)
- reset  in  1  asynchronous, active-low reset
- row_keys  in  ROWS  raw row returns, active-high, asynchronous
- col_keys  out  COLS  one-hot column drive, active-high
- key_valid  out  1  one-cycle strobe: key_index accepted
- key_index  out  KW  row*COLS + col of the last accepted key
- key_held  out  1  high while the accepted key is held
- history  out  DIGITS*KW  accepted keys, newest in [KW-1:0]

## Operation
- Reset values: col_keys = 1 (column 0), key_valid = 0, key_index = 0, key_held = 0, history = 0, state SCAN, all counters 0.
- row_keys pass through a 2-FF synchroniser. Only the synchronised value (rs) is used.
- SCAN:
  - The dwell counter increments every cycle.
  - Sampling is legal when dwell ≥ 2, which covers synchroniser latency after a column change.
  - If sampling is legal and rs ≠ 0: capture the lowest-index set row and the current column, clear the counter, go to DEBOUNCE.
  - Otherwise, at dwell = SCAN_CYCLES-1: rotate col_keys left (COLS-1 wraps to 0) and clear dwell.
- DEBOUNCE: columns frozen; count cycles.
  - If the captured row bit drops, return to SCAN on the same column with dwell cleared.
  - At count = DEBOUNCE_CYCLES go to ACCEPT.
- ACCEPT (1 cycle): key_valid = 1; key_index = captured; history shifts up one slot with the new key in slot 0 and the oldest discarded; key_held = 1; go to HOLD.
- HOLD: columns frozen.
  - When the captured row bit drops: clear the counter, go to RELEASE.
  - If REPEAT_CYCLES ≠ 0: after every REPEAT_CYCLES held cycles, pulse key_valid and shift history again.
  - Presses on other rows or columns are ignored (no rollover).
- RELEASE: count cycles.
  - If the captured row bit reasserts, return to HOLD with the repeat counter reset and no new strobe.
  - At count = DEBOUNCE_CYCLES: key_held = 0, advance to the next column, go to SCAN.
- Counters are sized to $clog2(max value + 1) and saturate only via the state transitions.
- An asserted reset mid-operation aborts immediately to reset values. No strobe is produced on reset release.

## Timing
- If rs first qualifies in SCAN at cycle t, DEBOUNCE occupies t+1 … t+DEBOUNCE_CYCLES and key_valid is high at t+DEBOUNCE_CYCLES+1.
- Pin-to-strobe latency is therefore 2 + DEBOUNCE_CYCLES + 1 cycles after a stable press on the driven column.
- key_index and history update on the same edge key_valid rises. They are stable until the next strobe.
- Repeat strobes occur at ACCEPT + k·REPEAT_CYCLES (k ≥ 1) while held, each exactly one cycle wide.
- key_held falls on the same edge that col_keys advances out of RELEASE.
- Full column sweep with no key pressed = COLS·SCAN_CYCLES cycles.

## Structure
- Package keypad_pkg holds:
  - the typedef enum logic [2:0] {SCAN, DEBOUNCE, ACCEPT, HOLD, RELEASE} scan_state_t
  - a cnt_width(max) function for counter sizing.
- One sub-module, sync_2ff #(WIDTH), is the parametrised two-flop synchroniser, reused by other pin inputs.
- The index-to-hex mapping stays outside this block, in the existing decoder.

## Test plan
Bench parameters: ROWS=4, COLS=4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=0, DIGITS=2.
- Idle sweep: no press for 32 cycles → col_keys steps 0001→0010→0100→1000→0001 every 4 cycles; key_valid never asserts.
- Clean press of row 2 while col_keys = 0100 (col 2) → one key_valid; key_index = 10; history = {0, 10}; key_held high until 8 cycles after release.
- Bounce: row 1 on col 0 toggles after 3 debounce cycles → no key_valid; scanning resumes on col 0.
- Two presses (index 5, then 15) → history = {5, 15}, with 15 in the low slot. A third press (0) → history = {15, 0}.
- With REPEAT_CYCLES=16, hold index 3 for 60 cycles → strobes at ACCEPT, +16, +32, +48; release glitch shorter than 8 cycles → no extra strobe.
- Assert reset during HOLD → all outputs return to reset values immediately; the first strobe after reset release needs a fresh full debounce.
